// File: rtl/two_bit_shift_pkg.sv
// Shared definitions for the 2-bit serial link: direction encoding and
// beat-count sizing helpers used by both the shifter and the deserializer.
package two_bit_shift_pkg;

    typedef enum logic {
        DIR_LSB_FIRST = 1'b0,
        DIR_MSB_FIRST = 1'b1
    } dir_e;

    function automatic int beats_of(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_BEATS = beats_of(DEFAULT_WIDTH);

    typedef logic [cnt_width(DEFAULT_BEATS)-1:0] beat_cnt_t;

endpackage

// File: rtl/two_bit_deserializer_if.sv
// Serial-in beat handshake and parallel-out word handshake of the 2-bit
// deserializer; the deserializer is the slave, the link/consumer side the master.
interface two_bit_deserializer_if #(parameter int WIDTH = 8);

    logic             sin_valid;
    logic             sin_ready;
    logic [1:0]       sin;
    logic             msb_first;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    modport slave (
        input  sin_valid, sin, msb_first, dout_ready,
        output sin_ready, dout, dout_valid, busy
    );

    modport master (
        output sin_valid, sin, msb_first, dout_ready,
        input  sin_ready, dout, dout_valid, busy
    );

endinterface

// File: rtl/two_bit_deserializer.sv
// Reassembles 2-bit beats into WIDTH-bit words, MSB-first or LSB-first per
// word, with a single registered output slot and back-pressure on the final beat.
module two_bit_deserializer
    import two_bit_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    two_bit_deserializer_if.slave  bus
);

    localparam int                BEATS     = beats_of(WIDTH);
    localparam int                CNT_W     = cnt_width(BEATS);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("two_bit_deserializer: WIDTH must be even and >= 4");
        end
    endgenerate

    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    dir_e             dir_q,   dir_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             valid_q, valid_d;

    logic             first_s;
    logic             last_s;
    logic             ready_s;
    logic             accept_s;
    dir_e             eff_dir_s;
    logic [WIDTH-1:0] shifted_s;

    // Only the final beat can stall, and only while the output slot is full and not draining.
    assign first_s   = (cnt_q == {CNT_W{1'b0}});
    assign last_s    = (cnt_q == LAST_BEAT);
    assign ready_s   = !(last_s && valid_q && !bus.dout_ready);
    assign accept_s  = bus.sin_valid && ready_s && !clr_i;
    assign eff_dir_s = first_s ? dir_e'(bus.msb_first) : dir_q;

    // Shift the incoming beat into the accumulator in the word's direction.
    always_comb begin
        shifted_s = acc_q;
        if (eff_dir_s == DIR_MSB_FIRST) begin
            shifted_s = {acc_q[WIDTH-3:0], bus.sin};
        end else begin
            shifted_s = {bus.sin, acc_q[WIDTH-1:2]};
        end
    end

    // Next-state for accumulator, beat counter and direction; clr wins over a beat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clr_i) begin
            acc_d = {WIDTH{1'b0}};
            cnt_d = {CNT_W{1'b0}};
        end else if (accept_s) begin
            acc_d = shifted_s;
            dir_d = eff_dir_s;
            if (last_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Output slot: a completing word overrides a same-cycle drain.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        if (accept_s && last_s) begin
            dout_d  = shifted_s;
            valid_d = 1'b1;
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            dir_q   <= DIR_MSB_FIRST;
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign bus.sin_ready  = ready_s;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = !first_s;

endmodule

// File: doc/two_bit_deserializer.md
# two_bit_deserializer

Receive-side counterpart of the 2-bit shifter: accepts a stream of 2-bit beats and reassembles them into WIDTH-bit parallel words. The shift direction is selectable per word, covering both MSB-first (shift-left) and LSB-first (shift-right) streams. Completed words are presented on a valid/ready output with back-pressure to the serial side. It sits at the far end of any 2-bit serial link fed by the shifter.

## Interface
- WIDTH, 8, output word width; must be even and >= 4; BEATS = WIDTH/2.
- CLK  input  1  clock, all state updates on rising edge.
- RSTn  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush of partial word.
- sin_valid  input  1  beat present on sin.
- sin_ready  output  1  block can accept a beat this cycle.
- sin  input  2  beat data; sin[1] is the more significant bit of the pair in both modes.
- msb_first  input  1  1 = MSB-first (shift-left assembly), 0 = LSB-first (shift-right assembly); sampled on first beat of a word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout.
- busy  output  1  partial word in progress (beat_cnt != 0).

## Operation
- State: accumulator acc[WIDTH-1:0], beat counter beat_cnt (0..BEATS-1), latched direction dir, output register dout plus dout_valid.
- Beat accepted when sin_valid && sin_ready.
- MSB-first: acc <= {acc[WIDTH-3:0], sin}. LSB-first: acc <= {sin, acc[WIDTH-1:2]}.
- On accepted beat with beat_cnt == 0: dir <= msb_first, and that same beat is shifted using the new msb_first value. msb_first changes mid-word are ignored.
- beat_cnt increments on each accepted beat and wraps BEATS-1 -> 0.
- Final beat (beat_cnt == BEATS-1):
  - The fully shifted value is written directly to dout, and dout_valid <= 1.
  - acc is not required to hold it.
- dout_valid clears when dout_valid && dout_ready and no new word completes in that cycle.
- A word completing in the same cycle as a drain keeps dout_valid at 1 with the new data.
- sin_ready = !(beat_cnt == BEATS-1 && dout_valid && !dout_ready). Non-final beats are never stalled.
- clr:
  - Sets beat_cnt <= 0 and acc <= 0; any sin beat in that cycle is discarded.
  - clr has priority over sin_valid.
  - dout and dout_valid are unaffected, and a drain in the same cycle still completes.

## Timing
- Reset values: dout = 0, dout_valid = 0, sin_ready = 1, busy = 0; internally acc = 0, beat_cnt = 0, dir = 1.
- Reset is asynchronous and takes effect mid-word: the partial word is lost, and a pending dout is lost.
- Latency: dout_valid rises on the clock edge that accepts the final beat, so it is visible in the following cycle.
- Throughput: one word per BEATS cycles with continuous sin_valid and dout_ready held high; there are no bubbles between words.
- Stall:
  - While the output is full and not draining, the final beat is held (sin_ready = 0).
  - The source must keep sin and sin_valid stable until accepted.
  - dout must stay stable while dout_valid && !dout_ready.
- busy reflects the registered beat_cnt only and has no combinational path from sin_valid.

## Structure
- Shared package two_bit_shift_pkg:
  - localparam BEATS derivation helper.
  - Direction enum {DIR_LSB_FIRST = 0, DIR_MSB_FIRST = 1}, shared with the shifter's SHL/SHR mapping.
  - Beat-count typedef sized $clog2(BEATS).
- Single module; no sub-module. Accumulator, counter and output register are small enough to stay flat.
- Add an elaboration-time check that rejects odd WIDTH or WIDTH < 4.

## Test plan
- MSB-first assembly: after reset, msb_first = 1, beats 11, 00, 01, 10 on consecutive cycles with dout_ready = 1 -> dout = 8'hC6 and dout_valid high for exactly one cycle, one cycle after the 4th beat.
- LSB-first assembly: msb_first = 0, same beats -> dout = 8'h93.
- Mid-word direction change: set msb_first = 1 on beat 0, toggle it to 0 on beats 1–3 with beats 11, 00, 01, 10 -> dout = 8'hC6.
- Back-pressure:
  - Stimulus: word A = 8'hC6 completes with dout_ready = 0; word B is streamed behind it.
  - Stall: sin_ready drops only on B's final beat, and dout holds 8'hC6.
  - Release: raising dout_ready accepts B in that same cycle, and dout = B next cycle with dout_valid still 1.
- clr and reset:
  - clr after 2 beats then 4 fresh beats of 10 (msb_first = 1) -> dout = 8'hAA.
  - clr coincident with a beat discards it.
  - RSTn low mid-word -> dout = 0, dout_valid = 0, busy = 0 immediately, without waiting for a clock edge.
- Continuous streaming: 3 back-to-back words with dout_ready = 1 -> dout_valid pulses every 4 cycles with correct data and sin_ready never deasserts.
